pattern_encoder: RTL and testbench
==================================

PATTERN_ENCODER -- requirements
Module: pattern_encoder

Interface
REQ-001 Parameter: WIDTH, default 32, width of the pattern word; the block SHALL support only WIDTH >= 27.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: in_valid  input  1  data_in carries a pattern this cycle.
REQ-005 Port: in_ready  output  1  block accepts data_in this cycle; a transfer occurs when in_valid && in_ready.
REQ-006 Port: data_in  input  WIDTH  pattern word to encode.
REQ-007 Port: out_valid  output  1  code/match hold a result.
REQ-008 Port: out_ready  input  1  downstream accepts the result; a transfer occurs when out_valid && out_ready.
REQ-009 Port: code  output  3  encoded index of the matched pattern.
REQ-010 Port: match  output  1  data_in equalled one of the eight legal patterns.
REQ-011 Port: miss_cnt  output  16  saturating count of accepted non-matching words.
REQ-012 Port: clr  input  1  synchronous clear of miss_cnt only.

Function
REQ-013 Legal patterns (decimal, zero-extended to WIDTH) SHALL map to: 0 -> code 0; 11111101 -> 1; 11111011 -> 2; 11110111 -> 3; 11101111 -> 4; 11011111 -> 5; 10111111 -> 6; 01111111 (=1111111) -> 7.
REQ-014 Comparison SHALL be on all WIDTH bits exactly; any other value SHALL produce match=0, code=3'b000.
REQ-015 Pipeline SHALL be two register stages: S1 captures data_in on input transfer; S2 captures the comparison result (code, match) from S1.
REQ-016 Latency SHALL be 2 cycles: word accepted on edge N appears with out_valid=1 after edge N+2 when no stall.
REQ-017 Throughput SHALL be one word per cycle while out_ready=1.
REQ-018 S2 load enable = !out_valid || out_ready; S1 load enable = !s1_valid || S2 load enable; in_ready SHALL equal S1 load enable (combinational, no dependency on in_valid).
REQ-019 While out_valid=1 and out_ready=0, code, match and out_valid SHALL hold stable; no word SHALL be dropped or duplicated.
REQ-020 When S1 advances into S2 and no new input transfers, s1_valid SHALL clear; bubbles SHALL not produce out_valid.
REQ-021 miss_cnt SHALL increment by 1 when a result with match=0 transfers out of S2 (out_valid && out_ready && !match).
REQ-022 miss_cnt SHALL saturate at 16'hFFFF and not wrap.
REQ-023 clr SHALL set miss_cnt to 0 on the next edge; if clr and an increment coincide, clr SHALL win (result 0).
REQ-024 Results SHALL emerge in acceptance order.

Reset
REQ-025 When rst=1 at a rising edge, s1_valid, out_valid, code, match and miss_cnt SHALL become 0; data registers SHALL become 0.
REQ-026 During rst=1, in_ready SHALL be driven 0; it SHALL reflect REQ-018 from the first cycle after rst deasserts.
REQ-027 Reset mid-operation SHALL discard any words in S1/S2 with no output transfer; rst SHALL take priority over clr, in_valid and out_ready.

Verification
REQ-028 Reset then in_valid=1, data_in=11111011, out_ready=1 -> two edges later out_valid=1, code=2, match=1.
REQ-029 Back-to-back inputs 0, 11111101, ..., 01111111 with out_ready=1 -> codes 0..7 in order on 8 consecutive cycles, match=1 each.
REQ-030 data_in=5 accepted -> out_valid=1, match=0, code=0; miss_cnt 0 -> 1 on output transfer.
REQ-031 Fill pipeline, hold out_ready=0 for 5 cycles -> in_ready=0 after both stages full, outputs stable; release -> both words delivered in order, none lost.
REQ-032 Preload miss_cnt to 16'hFFFF via non-matching stream -> further misses keep 16'hFFFF; assert clr with a miss transfer -> miss_cnt=0.
REQ-033 Assert rst with two words in flight -> out_valid=0, miss_cnt=0 next cycle; no stale result appears after deassertion.

Source files
------------

// File: rtl/pattern_encoder.sv
// pattern_encoder
// Two-stage valid/ready pipeline that recognises eight legal pattern words
// and encodes them to a 3-bit index. Stage 1 registers the accepted word,
// stage 2 registers the comparison result. A saturating counter tallies
// non-matching results as they leave the block.
//
// Pattern words are decimal constants zero-extended to WIDTH; the widest
// one fits in 24 bits, and WIDTH is expected to be at least 27.

module pattern_encoder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       code,
  output logic             match,
  output logic [15:0]      miss_cnt,
  input  logic             clr
);

  // Legal patterns, indexed by their code.
  localparam int NUM_PAT = 8;
  localparam logic [31:0] PAT_TABLE [NUM_PAT] = '{
    32'd0,
    32'd11111101,
    32'd11111011,
    32'd11110111,
    32'd11101111,
    32'd11011111,
    32'd10111111,
    32'd1111111
  };

  localparam logic [15:0] MISS_MAX = 16'hFFFF;

  // Stage 1 state
  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_data_reg;

  // Stage 2 state (drives the outputs directly)
  logic             out_valid_reg;
  logic [2:0]       code_reg;
  logic             match_reg;

  // Miss counter
  logic [15:0]      miss_cnt_reg;
  logic [15:0]      miss_cnt_next;

  // Handshake and comparison signals
  logic             s2_load;
  logic             s1_load;
  logic             in_fire;
  logic             out_fire;
  logic [NUM_PAT-1:0] hit_vec;
  logic [2:0]       code_next;
  logic             match_next;

  // Stage 2 may load when it is empty or its result is leaving this cycle;
  // stage 1 may load when it is empty or it can push into stage 2.
  assign s2_load  = !out_valid_reg || out_ready;
  assign s1_load  = !s1_valid_reg || s2_load;
  assign in_ready = !rst && s1_load;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_reg && out_ready;

  // One equality comparator per legal pattern, over the full word width.
  generate
    for (genvar gi = 0; gi < NUM_PAT; gi++) begin : g_cmp
      localparam logic [WIDTH-1:0] PAT_WORD = WIDTH'(PAT_TABLE[gi]);
      assign hit_vec[gi] = (s1_data_reg == PAT_WORD);
    end
  endgenerate

  // Patterns are distinct, so hit_vec is at most one-hot; OR-reduce indices.
  always_comb begin
    code_next  = 3'b000;
    match_next = |hit_vec;
    for (int i = 0; i < NUM_PAT; i++) begin
      if (hit_vec[i]) begin
        code_next = code_next | 3'(i);
      end
    end
  end

  // Stage 1: capture the word on an input transfer, drop to a bubble when
  // the held word advances with nothing new arriving.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
    end else if (s1_load) begin
      s1_valid_reg <= in_fire;
      if (in_fire) begin
        s1_data_reg <= data_in;
      end
    end
  end

  // Stage 2: register the comparison result; hold it while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      code_reg      <= 3'b000;
      match_reg     <= 1'b0;
    end else if (s2_load) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        code_reg  <= code_next;
        match_reg <= match_next;
      end
    end
  end

  // Next miss count: clear beats increment, and the count sticks at all-ones.
  always_comb begin
    miss_cnt_next = miss_cnt_reg;
    if (clr) begin
      miss_cnt_next = 16'h0000;
    end else if (out_fire && !match_reg && (miss_cnt_reg != MISS_MAX)) begin
      miss_cnt_next = miss_cnt_reg + 16'h0001;
    end
  end

  // Miss counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt_reg <= 16'h0000;
    end else begin
      miss_cnt_reg <= miss_cnt_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign code      = code_reg;
  assign match     = match_reg;
  assign miss_cnt  = miss_cnt_reg;

endmodule

// File: tb/tb_pattern_encoder.sv
// Directed bench for pattern_encoder: a vector table streamed back-to-back
// plus hand-written stall, saturation, clear and reset sequences.

module tb_pattern_encoder;

  localparam int WIDTH = 32;
  localparam int NVEC  = 14;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       code;
  logic             match;
  logic [15:0]      miss_cnt;
  logic             clr;

  int checks;
  int errors;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  code;
    logic        match;
  } vec_t;

  vec_t vecs [NVEC];

  pattern_encoder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .code      (code),
    .match     (match),
    .miss_cnt  (miss_cnt),
    .clr       (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_miss;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    clr       = 1'b0;

    // Legal patterns in code order, then near-misses.
    vecs[0]  = '{32'd0,                      3'd0, 1'b1};
    vecs[1]  = '{32'd11111101,               3'd1, 1'b1};
    vecs[2]  = '{32'd11111011,               3'd2, 1'b1};
    vecs[3]  = '{32'd11110111,               3'd3, 1'b1};
    vecs[4]  = '{32'd11101111,               3'd4, 1'b1};
    vecs[5]  = '{32'd11011111,               3'd5, 1'b1};
    vecs[6]  = '{32'd10111111,               3'd6, 1'b1};
    vecs[7]  = '{32'd1111111,                3'd7, 1'b1};
    vecs[8]  = '{32'd5,                      3'd0, 1'b0};
    vecs[9]  = '{32'd11111100,               3'd0, 1'b0};
    vecs[10] = '{32'd11111101 | 32'h0400_0000, 3'd0, 1'b0};
    vecs[11] = '{32'd1111111 | 32'h8000_0000,  3'd0, 1'b0};
    vecs[12] = '{32'hFFFF_FFFF,              3'd0, 1'b0};
    vecs[13] = '{32'd11101111,               3'd4, 1'b1};

    // Reset state
    step();
    step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_match",     {31'd0, match},     32'd0);
    check("rst_code",      {29'd0, code},      32'd0);
    check("rst_miss_cnt",  {16'd0, miss_cnt},  32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single legal word, two edges to the output
    in_valid  = 1'b1;
    data_in   = 32'd11111011;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat_edge1_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("lat_edge2_out_valid", {31'd0, out_valid}, 32'd1);
    check("lat_edge2_code",      {29'd0, code},      32'd2);
    check("lat_edge2_match",     {31'd0, match},     32'd1);
    $display("txn single data=%0d code=%0d match=%0d", 32'd11111011, code, match);
    step();
    check("bubble_out_valid", {31'd0, out_valid}, 32'd0);

    // Table streamed back-to-back; after edge k the output holds vecs[k-1]
    exp_miss = 0;
    for (int k = 0; k <= NVEC; k++) begin
      if (k < NVEC) begin
        in_valid = 1'b1;
        data_in  = vecs[k].data;
        check("stream_in_ready", {31'd0, in_ready}, 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (k >= 1) begin
        check("stream_out_valid", {31'd0, out_valid},      32'd1);
        check("stream_code",      {29'd0, code},           {29'd0, vecs[k-1].code});
        check("stream_match",     {31'd0, match},          {31'd0, vecs[k-1].match});
        $display("txn vec %0d data=%0h code=%0d match=%0d", k-1, vecs[k-1].data, code, match);
        if (!vecs[k-1].match) exp_miss++;
      end
    end
    step();
    check("stream_drained",  {31'd0, out_valid}, 32'd0);
    check("stream_miss_cnt", {16'd0, miss_cnt},  exp_miss);

    // Clear, then one miss counted 0 -> 1
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_miss_cnt", {16'd0, miss_cnt}, 32'd0);
    in_valid = 1'b1;
    data_in  = 32'd5;
    step();
    in_valid = 1'b0;
    step();
    check("miss5_out_valid", {31'd0, out_valid}, 32'd1);
    check("miss5_match",     {31'd0, match},     32'd0);
    check("miss5_code",      {29'd0, code},      32'd0);
    check("miss5_cnt_before", {16'd0, miss_cnt}, 32'd0);
    step();
    check("miss5_cnt_after", {16'd0, miss_cnt}, 32'd1);
    $display("txn miss data=5 miss_cnt=%0d", miss_cnt);

    // Stall: A then B fill both stages with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 32'd11110111;
    step();
    data_in = 32'd5;
    step();
    data_in = 32'd11011111;  // must not be accepted while full
    for (int c = 0; c < 5; c++) begin
      check("stall_in_ready",  {31'd0, in_ready},  32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_code",      {29'd0, code},      32'd3);
      check("stall_match",     {31'd0, match},     32'd1);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("release_a_code", {29'd0, code}, 32'd3);
    step();
    check("release_b_valid", {31'd0, out_valid}, 32'd1);
    check("release_b_code",  {29'd0, code},      32'd0);
    check("release_b_match", {31'd0, match},     32'd0);
    step();
    check("release_empty",   {31'd0, out_valid}, 32'd0);
    check("release_miss_cnt", {16'd0, miss_cnt}, 32'd2);
    $display("txn stall released miss_cnt=%0d", miss_cnt);

    // Saturation: stream enough misses to pass 16'hFFFF
    in_valid = 1'b1;
    data_in  = 32'd7;
    for (int c = 0; c < 65540; c++) step();
    check("sat_miss_cnt", {16'd0, miss_cnt}, 32'h0000_FFFF);
    step();
    step();
    check("sat_hold_miss_cnt", {16'd0, miss_cnt}, 32'h0000_FFFF);
    check("sat_out_valid",     {31'd0, out_valid}, 32'd1);
    clr = 1'b1;  // coincides with a miss transfer
    step();
    clr = 1'b0;
    check("clr_wins_miss_cnt", {16'd0, miss_cnt}, 32'd0);
    step();
    check("post_clr_count", {16'd0, miss_cnt}, 32'd1);
    $display("txn saturate then clear miss_cnt=%0d", miss_cnt);

    // Reset with two words in flight
    out_ready = 1'b0;
    data_in   = 32'd11111101;
    step();
    data_in = 32'd10111111;
    step();
    in_valid = 1'b0;
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("in_rst_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_miss_cnt",  {16'd0, miss_cnt},  32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
    end
    $display("txn reset in flight out_valid=%0d", out_valid);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
